// File: rtl/kamacore_data_mem_responder.sv
// Word-addressed data memory serving one load/store at a time over a valid/ready request/response pair.
// Latency: rsp_valid rises LATENCY cycles after the accept edge and holds until rsp_ready is seen.
// Backpressure: req_ready only in IDLE; a stalled response (rsp_ready low) also blocks new requests.
module kamacore_data_mem_responder #(
    parameter int CPU_WIDTH   = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [CPU_WIDTH-1:0]   req_addr,
    input  logic [CPU_WIDTH-1:0]   req_wdata,
    input  logic [CPU_WIDTH/8-1:0] req_be,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [CPU_WIDTH-1:0]   rsp_rdata,
    output logic                   rsp_err
);
    localparam int NBYTES = CPU_WIDTH / 8;
    localparam int OFFS   = $clog2(NBYTES);
    localparam int AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CPU_WIDTH-1:0] OFFS_MASK = CPU_WIDTH'((1 << OFFS) - 1);
    localparam logic [CPU_WIDTH-1:0] DEPTH_LIM = CPU_WIDTH'(DEPTH_WORDS);
    localparam logic [3:0]           CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           cnt;
    logic [3:0]           cnt_nxt;
    logic                 live;
    logic                 accept;
    logic                 req_bad;
    logic [CPU_WIDTH-1:0] word_idx;
    logic [CPU_WIDTH-1:0] rdata_q;
    logic                 err_q;
    logic [CPU_WIDTH-1:0] mem [DEPTH_WORDS];

    // Decode of the presented request: word index, and misaligned / out-of-range error.
    assign word_idx = req_addr >> OFFS;
    assign req_bad  = ((req_addr & OFFS_MASK) != '0) || (word_idx >= DEPTH_LIM);

    // live holds req_ready low until the first clock edge after reset release.
    assign req_ready = live && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Marks the responder usable from the first edge after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // State and latency counter registers; reset drops any pending response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: IDLE accepts, WAIT counts down LATENCY-1 cycles, RESP holds until taken.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Response payload captured at the accept edge so later request changes cannot leak in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= (!req_we && !req_bad) ? mem[word_idx[AW-1:0]] : '0;
            err_q   <= req_bad;
        end
    end

    // Byte-masked store at the accept edge; the array is deliberately never reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_bad) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (req_be[b]) begin
                    mem[word_idx[AW-1:0]][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_kamacore_data_mem_responder.sv
// Bench for the data memory responder: directed scenarios plus randomized traffic against a word-array model.
// Two instances: LATENCY=2 for most scenarios, LATENCY=1 for back-to-back spacing.
// Responses are sampled on the falling edge; stimulus changes on the falling edge or just after a rising edge.
module tb_kamacore_data_mem_responder;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        req_valid1 = 1'b0;
    logic        req_we1 = 1'b0;
    logic [31:0] req_addr1 = '0;
    logic [31:0] req_wdata1 = '0;
    logic [3:0]  req_be1 = '0;
    logic        rsp_ready1 = 1'b0;
    logic        req_ready1;
    logic        rsp_valid1;
    logic [31:0] rsp_rdata1;
    logic        rsp_err1;

    int n_checks = 0;
    int n_pass = 0;

    kamacore_data_mem_responder #(.CPU_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    kamacore_data_mem_responder #(.CPU_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1), .rsp_valid(rsp_valid1),
        .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    always #5 clk = ~clk;

    // One request on the LATENCY=2 instance. lat = cycles from accept edge to first valid (-1 on timeout);
    // stable = response held steady with req_ready low for every sampled cycle of the hold.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat, output bit stable);
        int k;
        rdata = 'x;
        err = 1'bx;
        lat = -1;
        stable = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        if (!req_ready) begin req_valid = 1'b0; return; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        @(negedge clk);
        k = 0;
        while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
        if (!rsp_valid) return;
        lat = k + 1;
        rdata = rsp_rdata;
        err = rsp_err;
        stable = (req_ready === 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err || req_ready !== 1'b0)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_checks++; if ({req_ready, rsp_valid, rsp_err} !== 3'b000) $display("FAIL reset_ctl: got %b want 000", {req_ready, rsp_valid, rsp_err}); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rsp_rdata); else n_pass++;
        n_checks++; if ({req_ready1, rsp_valid1} !== 2'b00) $display("FAIL reset_l1: got %b want 00", {req_ready1, rsp_valid1}); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) $display("FAIL ready_in_reset: got %b want 0", req_ready); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", req_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL ready_after_edge: got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int lat; bit st;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st);
        n_checks++; if (lat !== 2) $display("FAIL basic_st_lat: got %0d want 2", lat); else n_pass++;
        n_checks++; if (er !== 1'b0 || rd !== 32'h0) $display("FAIL basic_st_rsp: got err %b data %h want 0/0", er, rd); else n_pass++;
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st);
        n_checks++; if (lat !== 2) $display("FAIL basic_ld_lat: got %0d want 2", lat); else n_pass++;
        n_checks++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) $display("FAIL basic_ld_rsp: got err %b data %h want 0/deadbeef", er, rd); else n_pass++;
    endtask

    task automatic test_merge();
        logic [31:0] rd; logic er; int lat; bit st;
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, st);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, rd, er, lat, st);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st);
        n_checks++; if (rd !== 32'h11BB33DD) $display("FAIL merge_be5: got %h want 11bb33dd", rd); else n_pass++;
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat, st);
        n_checks++; if (er !== 1'b0 || rd !== 32'h0 || lat !== 2) $display("FAIL be0_rsp: got err %b data %h lat %0d want 0/0/2", er, rd, lat); else n_pass++;
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st);
        n_checks++; if (rd !== 32'h11BB33DD) $display("FAIL be0_unchanged: got %h want 11bb33dd", rd); else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; bit st;
        txn(1'b0, 32'h22, 32'h0, 4'h0, 0, rd, er, lat, st);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL misaligned_ld: got err %b data %h want 1/0", er, rd); else n_pass++;
        txn(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, 0, rd, er, lat, st);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL range_ld: got err %b data %h want 1/0", er, rd); else n_pass++;
        txn(1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, st);
        n_checks++; if (er !== 1'b1) $display("FAIL misaligned_st: got err %b want 1", er); else n_pass++;
        txn(1'b1, 32'(4 * DEPTH + 32'h20), 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, st);
        n_checks++; if (er !== 1'b1) $display("FAIL range_st: got err %b want 1", er); else n_pass++;
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st);
        n_checks++; if (er !== 1'b0 || rd !== 32'h11BB33DD) $display("FAIL err_no_write: got err %b data %h want 0/11bb33dd", er, rd); else n_pass++;
    endtask

    task automatic test_hold();
        logic [31:0] rd; logic er; int lat; bit st;
        txn(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat, st);
        n_checks++; if (st !== 1'b1) $display("FAIL hold_stable: got %b want 1", st); else n_pass++;
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL hold_data: got %h want deadbeef", rd); else n_pass++;
        @(negedge clk);
        n_checks++; if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL hold_release: got %b want 10", {req_ready, rsp_valid}); else n_pass++;
    endtask

    task automatic test_rst_wait();
        logic [31:0] rd; logic er; int lat; bit st; bit bad;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rstw_ready: got %b want 1", req_ready); else n_pass++;
        @(posedge clk); #1 req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_rdata !== 32'h0) $display("FAIL rstw_outputs: got %b %h want 000 0", {req_ready, rsp_valid, rsp_err}, rsp_rdata); else n_pass++;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        repeat (6) begin @(negedge clk); if (rsp_valid !== 1'b0) bad = 1'b1; end
        n_checks++; if (bad !== 1'b0) $display("FAIL rstw_no_rsp: got stray response %b want 0", bad); else n_pass++;
        txn(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat, st);
        n_checks++; if (er !== 1'b0 || rd !== 32'h55) $display("FAIL rstw_kept: got err %b data %h want 0/55", er, rd); else n_pass++;
    endtask

    task automatic test_rst_resp();
        int k;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        @(posedge clk); #1 req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
        n_checks++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL rstr_pre: got %h want deadbeef", rsp_rdata); else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) $display("FAIL rstr_async: got %b %h want 0 0", rsp_valid, rsp_rdata); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back_l1();
        logic        we_a [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad_a [5] = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h40};
        logic [31:0] wd_a [5] = '{32'hA5A50001, 32'h0, 32'h0BADF00D, 32'h0, 32'h0};
        logic [31:0] ex_a [5] = '{32'h0, 32'hA5A50001, 32'h0, 32'h0BADF00D, 32'hA5A50001};
        int acc_t[$]; int rsp_t[$]; logic [31:0] got[$];
        int idx; bit pend; int n;
        idx = 0; pend = 1'b0;
        rsp_ready1 = 1'b1;
        @(negedge clk);
        req_valid1 = 1'b1; req_we1 = we_a[0]; req_addr1 = ad_a[0]; req_wdata1 = wd_a[0]; req_be1 = 4'hF;
        for (int t = 0; t < 40 && rsp_t.size() < 5; t++) begin
            if (pend) begin
                pend = 1'b0;
                idx++;
                if (idx < 5) begin
                    req_we1 = we_a[idx]; req_addr1 = ad_a[idx]; req_wdata1 = wd_a[idx];
                end else begin
                    req_valid1 = 1'b0;
                end
            end
            if (rsp_valid1) begin rsp_t.push_back(t); got.push_back(rsp_rdata1); end
            if (req_valid1 && req_ready1) begin acc_t.push_back(t); pend = 1'b1; end
            @(negedge clk);
        end
        req_valid1 = 1'b0; rsp_ready1 = 1'b0;
        n_checks++; if (acc_t.size() != 5 || rsp_t.size() != 5) $display("FAIL l1_counts: got acc %0d rsp %0d want 5/5", acc_t.size(), rsp_t.size()); else n_pass++;
        n = (acc_t.size() < rsp_t.size()) ? acc_t.size() : rsp_t.size();
        for (int i = 0; i < n; i++) begin
            n_checks++; if (rsp_t[i] - acc_t[i] != 1) $display("FAIL l1_latency[%0d]: got %0d want 1", i, rsp_t[i] - acc_t[i]); else n_pass++;
            n_checks++; if (got[i] !== ex_a[i]) $display("FAIL l1_data[%0d]: got %h want %h", i, got[i], ex_a[i]); else n_pass++;
            if (i > 0) begin
                n_checks++; if (acc_t[i] - acc_t[i-1] != 2) $display("FAIL l1_spacing[%0d]: got %0d want 2", i, acc_t[i] - acc_t[i-1]); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [16];
        logic [31:0] rd; logic er; int lat; bit st;
        logic [31:0] addr, wd, exp_rd, w;
        logic [3:0] be;
        logic we, exp_err;
        int kind, hold, widx;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            txn(1'b1, 32'(i * 4), wd, 4'hF, 0, rd, er, lat, st);
            ref_mem[i] = wd;
            n_checks++; if (er !== 1'b0 || lat !== 2) $display("FAIL rnd_init[%0d]: got err %b lat %0d want 0/2", i, er, lat); else n_pass++;
        end
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7)      addr = 32'($urandom_range(0, 15) * 4);
            else if (kind < 9) addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else               addr = 32'(DEPTH * 4 + $urandom_range(0, 15) * 4);
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            hold = $urandom_range(0, 3);
            widx = int'(addr / 4);
            exp_err = (addr % 4 != 0) || (widx >= DEPTH);
            exp_rd = (we || exp_err) ? 32'h0 : ref_mem[widx % 16];
            txn(we, addr, wd, be, hold, rd, er, lat, st);
            if (we && !exp_err) begin
                w = ref_mem[widx];
                for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
                ref_mem[widx] = w;
            end
            n_checks++; if (rd !== exp_rd) $display("FAIL rnd_data[%0d]: got %h want %h", n, rd, exp_rd); else n_pass++;
            n_checks++; if (er !== exp_err) $display("FAIL rnd_err[%0d]: got %b want %b", n, er, exp_err); else n_pass++;
            n_checks++; if (lat !== 2) $display("FAIL rnd_lat[%0d]: got %0d want 2", n, lat); else n_pass++;
            n_checks++; if (st !== 1'b1) $display("FAIL rnd_stable[%0d]: got %b want 1", n, st); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_merge();
        test_errors();
        test_hold();
        test_rst_wait();
        test_rst_resp();
        test_back_to_back_l1();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
